maxcut_search: RTL

Sequential search engine that sits directly upstream of the combinational max-cut decision checker. It drives the checker's vertex inputs `a`–`e` and threshold `cut`, samples the checker's `valid`, and sweeps all 32 vertex assignments to find the maximum cut size and a witness assignment. A `start`/`done` handshake lets a host or testbench launch a search and collect `best` and `witness`.

---
 rtl/maxcut_search_if.sv | 29 ++
 rtl/maxcut_search.sv | 90 +++++++++
 2 files changed

// File: rtl/maxcut_search_if.sv
// Host/checker bundle for the max-cut search engine.
// slave = the search engine, master = host plus checker side.
interface maxcut_search_if #(
    parameter int BITS  = 3,
    parameter int VERTS = 5
);
    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             e;
    logic [BITS-1:0]  cut;
    logic             valid;
    logic             busy;
    logic             done;
    logic [BITS-1:0]  best;
    logic [VERTS-1:0] witness;

    modport slave (
        input  start, valid,
        output a, b, c, d, e, cut, busy, done, best, witness
    );

    modport master (
        output start, valid,
        input  a, b, c, d, e, cut, busy, done, best, witness
    );
endinterface

// File: rtl/maxcut_search.sv
// Sweeps all vertex assignments against a combinational max-cut checker,
// raising the threshold on each hit to find the max cut and a witness.
module maxcut_search #(
    parameter int BITS  = 3,
    parameter int VERTS = 5
) (
    input logic             clk,
    input logic             rst,
    maxcut_search_if.slave  bus
);
    localparam logic [BITS-1:0]  BMAX = '1;
    localparam logic [VERTS-1:0] AMAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [VERTS-1:0] asg_q;
    logic [VERTS-1:0] asg_d;
    logic [VERTS-1:0] wit_q;
    logic [VERTS-1:0] wit_d;
    logic [BITS-1:0]  best_q;
    logic [BITS-1:0]  best_d;
    logic [BITS-1:0]  thr;
    logic             sat;
    logic             hit;

    // A saturated best holds the threshold at max instead of wrapping to 0.
    assign sat = (best_q == BMAX);
    assign thr = sat ? BMAX : best_q + 1'b1;
    assign hit = bus.valid && !sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            asg_q   <= '0;
            wit_q   <= '0;
            best_q  <= '0;
        end else begin
            state_q <= state_d;
            asg_q   <= asg_d;
            wit_q   <= wit_d;
            best_q  <= best_d;
        end
    end

    always_comb begin
        state_d = state_q;
        asg_d   = asg_q;
        wit_d   = wit_q;
        best_d  = best_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    asg_d   = '0;
                    wit_d   = '0;
                    best_d  = '0;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                if (hit) begin
                    best_d = best_q + 1'b1;
                    wit_d  = asg_q;
                end else if (asg_q == AMAX) begin
                    state_d = DONE;
                end else begin
                    asg_d = asg_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q == PROBE);
    assign bus.done    = (state_q == DONE);
    assign bus.cut     = bus.busy ? thr : '0;
    assign bus.best    = best_q;
    assign bus.witness = wit_q;
    assign {bus.a, bus.b, bus.c, bus.d, bus.e} = asg_q;
endmodule
